// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the single-bit full-subtractor equations.
package arith_pkg;

    // 2'd3 has no name on purpose; the FSM sends it back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // One full-subtractor bit: returns {borrow_out, difference}.
    function automatic logic [1:0] fs_cell(input logic a, input logic b, input logic bin);
        logic d;
        logic bout;
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
        return {bout, d};
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational single-bit full subtractor, iterated LSB-first by the top level.
module full_subtractor
    import arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    logic [1:0] w_cell;

    assign w_cell = fs_cell(a, b, b_in);
    assign d      = w_cell[0];
    assign b_out  = w_cell[1];

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// with a single full-subtractor cell. Launched by a rising edge on start.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic             done,
    output logic             valid
);

    // Counter must reach WIDTH-1; at least one bit even when WIDTH=1.
    localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_start_q;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic             r_borrow_c;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;
    logic             r_valid;

    logic             w_trigger;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_next;

    assign w_trigger = start & ~r_start_q;

    // The new difference bit enters at the MSB so after WIDTH steps the
    // first (LSB) bit has shifted down to position 0.
    assign w_res_next = (r_res_sr >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

    full_subtractor u_cell (
        .a     (r_a_sr[0]),
        .b     (r_b_sr[0]),
        .b_in  (r_borrow_c),
        .d     (w_d),
        .b_out (w_bout)
    );

    // Next-state and step control; triggers during SHIFT are ignored.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_trigger) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_step = 1'b1;
                if (r_count == LAST_CNT) begin
                    w_last       = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register and start edge-detect flop.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state   <= ST_IDLE;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_start_q <= start;
        end
    end

    // Operand capture, serial shifting and the bit counter.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_a_sr     <= '0;
            r_b_sr     <= '0;
            r_res_sr   <= '0;
            r_borrow_c <= 1'b0;
            r_count    <= '0;
        end else if (w_load) begin
            r_a_sr     <= a;
            r_b_sr     <= b;
            r_borrow_c <= 1'b0;
            r_count    <= '0;
        end else if (w_step) begin
            r_a_sr     <= r_a_sr >> 1;
            r_b_sr     <= r_b_sr >> 1;
            r_res_sr   <= w_res_next;
            r_borrow_c <= w_bout;
            r_count    <= r_count + 1'b1;
        end
    end

    // Published result and status flags; diff keeps its old value until completion.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_busy  <= 1'b1;
                r_valid <= 1'b0;
            end else if (w_last) begin
                r_diff   <= w_res_next;
                r_borrow <= w_bout;
                r_busy   <= 1'b0;
                r_valid  <= 1'b1;
            end
        end
    end

    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign busy   = r_busy;
    assign done   = r_done;
    assign valid  = r_valid;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed scenarios,
// randomized operations and an exhaustive operand sweep against a plain
// arithmetic model of a - b.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         start;
    logic [W-1:0] diff;
    logic         borrow;
    logic         busy;
    logic         done;
    logic         valid;

    int n_cmp;
    int n_bad;

    serial_subtractor #(.WIDTH(W)) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .a          (a),
        .b          (b),
        .start      (start),
        .diff       (diff),
        .borrow     (borrow),
        .busy       (busy),
        .done       (done),
        .valid      (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full operation with a reference result from integer arithmetic.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input bit scramble, input string tag);
        logic [W-1:0] exp_d;
        logic         exp_b;
        int           cyc;
        int           busy_cyc;
        exp_d    = W'(int'(ia) - int'(ib));
        exp_b    = (ia < ib);
        a        = ia;
        b        = ib;
        start    = 1'b1;
        tick();                      // E0
        start    = 1'b0;
        cyc      = 0;
        busy_cyc = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cyc++;
            if (scramble) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            tick();
            cyc++;
        end
        chk({tag, ".latency"}, cyc, W);
        chk({tag, ".busy_cycles"}, busy_cyc, W);
        chk({tag, ".diff"}, diff, exp_d);
        chk({tag, ".borrow"}, borrow, exp_b);
        chk({tag, ".valid"}, valid, 1);
        chk({tag, ".busy_end"}, busy, 0);
        tick();
        chk({tag, ".done_width"}, done, 0);
    endtask

    initial begin
        int n_done;
        int n_busy;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        a     = '0;
        b     = '0;
        start = 1'b0;

        // Reset state
        #2;
        chk("rst.diff", diff, 0);
        chk("rst.borrow", borrow, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.valid", valid, 0);
        #20 rst_n = 1'b1;
        tick();
        tick();

        // Basic and boundary values
        run_op(4'd9, 4'd5, 1'b0, "t1");
        run_op(4'd3, 4'd7, 1'b0, "t2a");
        run_op(4'd0, 4'd1, 1'b0, "t2b");
        run_op(4'd15, 4'd15, 1'b0, "t2c");

        // Start held high: exactly one operation
        a      = 4'd6;
        b      = 4'd2;
        start  = 1'b1;
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) n_done++;
            if (busy) n_busy++;
        end
        start = 1'b0;
        chk("t3.done_pulses", n_done, 1);
        chk("t3.busy_cycles", n_busy, W);
        chk("t3.diff", diff, 4);
        tick();

        // Rising edge of start while busy, with a changed: ignored
        a     = 4'd12;
        b     = 4'd5;
        start = 1'b1;
        tick();                      // E0
        start = 1'b0;
        tick();                      // E1
        a     = 4'd1;
        start = 1'b1;
        tick();                      // E2
        start = 1'b0;
        tick();                      // E3
        chk("t4.not_done_early", done, 0);
        tick();                      // E4
        chk("t4.done_on_time", done, 1);
        chk("t4.diff", diff, 7);
        chk("t4.borrow", borrow, 0);
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) n_done++;
            if (busy) n_busy++;
        end
        chk("t4.extra_done", n_done, 0);
        chk("t4.extra_busy", n_busy, 0);

        // Asynchronous reset in the middle of SHIFT
        a     = 4'd9;
        b     = 4'd5;
        start = 1'b1;
        tick();                      // E0
        start = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5.diff", diff, 0);
        chk("t5.borrow", borrow, 0);
        chk("t5.busy", busy, 0);
        chk("t5.done", done, 0);
        chk("t5.valid", valid, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) n_done++;
            if (busy) n_busy++;
        end
        chk("t5.no_done", n_done, 0);
        chk("t5.no_busy", n_busy, 0);
        run_op(4'd8, 4'd3, 1'b0, "t5b");

        // Randomized operands, changed under the DUT during SHIFT
        for (int i = 0; i < 30; i++) begin
            run_op(W'($urandom), W'($urandom), 1'b1, "rnd");
        end

        // Exhaustive operand sweep
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                run_op(W'(ia), W'(ib), 1'b0, "exh");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
